param_matrix_colorspace_converter: RTL
======================================

Name: param_matrix_colorspace_converter

Overview:
Parametrised 3-channel colorspace converter. Applies a runtime-programmable 3x3 signed fixed-point matrix plus per-channel offsets to each pixel, with rounding and saturation. Input and output use a valid/ready stream interface with an internal output FIFO and credit-based backpressure. Sits between the pixel capture path and the edge-detection kernels (grayscale mode feeds the Sobel path directly).

Parameters:
CHANNEL_WIDTH, 8, bits per colour channel (unsigned).
COEFF_WIDTH, 12, signed coefficient width; must be >= CHANNEL_WIDTH+2.
FRAC_BITS, 8, fractional bits of coefficients; must be >= 1 and < COEFF_WIDTH.
FIFO_DEPTH, 8, output FIFO entries; power of two, >= 4.

Ports:
clock  in  1  system clock; all logic on rising edge.
reset  in  1  asynchronous, active-high reset.
enable  in  1  1 = accept new pixels; 0 = in_ready forced low, pipeline and FIFO keep draining.
mode  in  2  0 = bypass, 1 = matrix, 2 = grayscale, 3 = reserved (behaves as bypass); sampled with each accepted pixel.
in_valid  in  1  input pixel valid.
in_ready  out  1  input pixel accepted when in_valid && in_ready.
in_pixel  in  3*CHANNEL_WIDTH  channel 0 in LSBs.
out_valid  out  1  FIFO head valid.
out_ready  in  1  consumer ready; pop on out_valid && out_ready.
out_pixel  out  3*CHANNEL_WIDTH  FIFO head, channel 0 in LSBs.
coeff_we  in  1  write coeff_data to shadow register coeff_addr.
coeff_addr  in  4  0-8 = matrix row-major (row r, col c = 3r+c); 9-11 = offset for output channel 0-2; 12-15 ignored.
coeff_data  in  COEFF_WIDTH  signed; offsets are signed integers (not fractional).
coeff_commit  in  1  copy shadow bank to active bank.
fifo_count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (async assert, sync deassert): in_ready, out_valid, out_pixel, fifo_count = 0; pipeline valids cleared; FIFO emptied; shadow and active banks = identity (diagonal = 1<<FRAC_BITS, others 0, offsets 0). Reset mid-stream drops all in-flight and buffered pixels.
- Pipeline: S1 register pixel + mode + 9 products using active bank; S2 row sums plus (offset<<FRAC_BITS) plus rounding constant 1<<(FRAC_BITS-1); S3 arithmetic shift right FRAC_BITS, clamp to [0, 2^CHANNEL_WIDTH-1], FIFO write. Accepted in cycle N -> FIFO write at end of cycle N+3; out_valid visible in cycle N+4 when FIFO was empty. Throughput 1 pixel/cycle.
- Accumulator width COEFF_WIDTH+CHANNEL_WIDTH+3 signed; no internal overflow allowed.
- Bypass: input copied unchanged, same 4-cycle latency (ordering preserved across mode changes).
- Grayscale: row-0 result replicated to all three output channels.
- Credit: in_ready = enable && (fifo_count + inflight_count < FIFO_DEPTH), inflight_count = valid stages S1-S3. FIFO never overflows; no pixel is dropped under any out_ready pattern.
- Simultaneous push and pop: both occur, fifo_count unchanged. Pop when empty: ignored. Pointers wrap modulo FIFO_DEPTH.
- Coefficients: coeff_we writes shadow only. coeff_commit copies all 12 shadow registers to active at the clock edge; a pixel accepted in the same cycle uses the old bank, the next pixel uses the new one. coeff_we and coeff_commit in the same cycle: commit copies the pre-write shadow value; the write lands in shadow.
- out_pixel holds its value while out_valid && !out_ready.

Test Plan:
- Reset/bypass: mode=0, push (0x12,0x34,0x56) -> same pixel out 4 cycles later; mode=1 after reset (identity) -> same pixel.
- BT.601 matrix (FRAC_BITS=8): rows (77,150,29),(-43,-85,128),(128,-107,-21), offsets (0,128,128), commit; white (255,255,255) -> (255,128,128); red (255,0,0) -> (77,85,255), Cr saturated from 256.
- Grayscale mode, same bank, red (255,0,0) -> (77,77,77); negative sum (row 0 = -256,0,0, pixel 10) -> clamps to 0.
- Backpressure: out_ready=0, stream 20 pixels -> in_ready drops after exactly FIFO_DEPTH accepts, fifo_count=8; random out_ready afterwards -> all 20 delivered in order, none dropped or duplicated.
- Commit mid-stream: continuous stream, commit between pixels k and k+1 -> pixel k uses old bank, k+1 new; same-cycle we+commit follows the rule above.
- Reset mid-operation: assert reset with FIFO at 5 entries and 3 in flight -> out_valid=0, fifo_count=0 immediately, identity coefficients restored.

Source files
------------

// File: rtl/param_matrix_colorspace_converter.sv
// 3-channel colorspace converter: programmable 3x3 signed fixed-point matrix plus offsets,
// 3-stage pipeline into an output FIFO with credit-based input backpressure.
module param_matrix_colorspace_converter #(
    parameter int CHANNEL_WIDTH = 8,
    parameter int COEFF_WIDTH   = 12,
    parameter int FRAC_BITS     = 8,
    parameter int FIFO_DEPTH    = 8
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            enable,
    input  logic [1:0]                      mode,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [3*CHANNEL_WIDTH-1:0]      in_pixel,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [3*CHANNEL_WIDTH-1:0]      out_pixel,
    input  logic                            coeff_we,
    input  logic [3:0]                      coeff_addr,
    input  logic signed [COEFF_WIDTH-1:0]   coeff_data,
    input  logic                            coeff_commit,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_count
);

    localparam int PIX_W  = 3 * CHANNEL_WIDTH;
    localparam int PROD_W = COEFF_WIDTH + CHANNEL_WIDTH + 1;
    localparam int ACC_W  = COEFF_WIDTH + CHANNEL_WIDTH + 3;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int NUM_COEFFS = 12;

    typedef logic signed [COEFF_WIDTH-1:0] coeff_t;
    typedef logic signed [ACC_W-1:0]       acc_t;

    typedef enum logic [1:0] {
        MODE_BYPASS = 2'd0,
        MODE_MATRIX = 2'd1,
        MODE_GRAY   = 2'd2,
        MODE_RSVD   = 2'd3
    } mode_t;

    localparam coeff_t ONE_Q   = coeff_t'(1 << FRAC_BITS);
    localparam acc_t   ROUND   = acc_t'(1 << (FRAC_BITS - 1));
    localparam acc_t   ACC_MAX = acc_t'((1 << CHANNEL_WIDTH) - 1);

    function automatic coeff_t identity_coeff(input int unsigned idx);
        return (idx == 0 || idx == 4 || idx == 8) ? ONE_Q : '0;
    endfunction

    function automatic logic [CHANNEL_WIDTH-1:0] clamp_channel(input acc_t acc);
        acc_t q;
        q = acc >>> FRAC_BITS;
        if (q[ACC_W-1]) begin
            return '0;
        end else if (q > ACC_MAX) begin
            return '1;
        end
        return q[CHANNEL_WIDTH-1:0];
    endfunction

    // ------------------------------------------------------------------
    // Coefficient banks
    // ------------------------------------------------------------------
    coeff_t shadow [NUM_COEFFS];
    coeff_t active [NUM_COEFFS];

    // Commit reads the shadow value from before any same-cycle write.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_COEFFS; i++) begin
                shadow[i] <= identity_coeff(i);
                active[i] <= identity_coeff(i);
            end
        end else begin
            if (coeff_we && coeff_addr < 4'd12) begin
                shadow[coeff_addr] <= coeff_data;
            end
            if (coeff_commit) begin
                for (int unsigned i = 0; i < NUM_COEFFS; i++) begin
                    active[i] <= shadow[i];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Credit and handshake
    // ------------------------------------------------------------------
    logic           s1_valid, s2_valid, s3_valid;
    logic [CNT_W:0] occupancy;
    logic           accept;
    logic           push, pop;

    assign occupancy = {1'b0, fifo_count} + (CNT_W + 1)'(s1_valid)
                     + (CNT_W + 1)'(s2_valid) + (CNT_W + 1)'(s3_valid);
    assign in_ready  = !reset && enable && (occupancy < (CNT_W + 1)'(FIFO_DEPTH));
    assign accept    = in_valid && in_ready;

    // ------------------------------------------------------------------
    // Stage 1: products against the active bank
    // ------------------------------------------------------------------
    logic signed [PROD_W-1:0] prod_next [9];
    logic signed [PROD_W-1:0] s1_prod   [9];
    coeff_t                   s1_off    [3];
    mode_t                    s1_mode;
    logic [PIX_W-1:0]         s1_pixel;

    always_comb begin
        for (int unsigned r = 0; r < 3; r++) begin
            for (int unsigned c = 0; c < 3; c++) begin
                prod_next[3*r+c] = PROD_W'(active[3*r+c])
                                 * PROD_W'($signed({1'b0, in_pixel[c*CHANNEL_WIDTH +: CHANNEL_WIDTH]}));
            end
        end
    end

    // Offsets travel with the pixel so a later commit cannot split one pixel across banks.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_mode  <= MODE_BYPASS;
            s1_pixel <= '0;
            for (int unsigned i = 0; i < 9; i++) s1_prod[i] <= '0;
            for (int unsigned r = 0; r < 3; r++) s1_off[r] <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_mode  <= mode_t'(mode);
                s1_pixel <= in_pixel;
                for (int unsigned i = 0; i < 9; i++) s1_prod[i] <= prod_next[i];
                for (int unsigned r = 0; r < 3; r++) s1_off[r] <= active[9+r];
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: row sums with offset and rounding
    // ------------------------------------------------------------------
    acc_t             sum_next [3];
    acc_t             s2_sum   [3];
    mode_t            s2_mode;
    logic [PIX_W-1:0] s2_pixel;

    always_comb begin
        for (int unsigned r = 0; r < 3; r++) begin
            sum_next[r] = ACC_W'(s1_prod[3*r]) + ACC_W'(s1_prod[3*r+1]) + ACC_W'(s1_prod[3*r+2])
                        + (ACC_W'(s1_off[r]) <<< FRAC_BITS) + ROUND;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s2_valid <= 1'b0;
            s2_mode  <= MODE_BYPASS;
            s2_pixel <= '0;
            for (int unsigned r = 0; r < 3; r++) s2_sum[r] <= '0;
        end else begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_mode  <= s1_mode;
                s2_pixel <= s1_pixel;
                for (int unsigned r = 0; r < 3; r++) s2_sum[r] <= sum_next[r];
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 3: shift, clamp, mode select
    // ------------------------------------------------------------------
    logic [CHANNEL_WIDTH-1:0] chan [3];
    logic [PIX_W-1:0]         result_next;
    logic [PIX_W-1:0]         s3_pixel;

    always_comb begin
        for (int unsigned r = 0; r < 3; r++) begin
            chan[r] = clamp_channel(s2_sum[r]);
        end
        result_next = s2_pixel;
        case (s2_mode)
            MODE_MATRIX: result_next = {chan[2], chan[1], chan[0]};
            MODE_GRAY:   result_next = {chan[0], chan[0], chan[0]};
            default:     result_next = s2_pixel;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s3_valid <= 1'b0;
            s3_pixel <= '0;
        end else begin
            s3_valid <= s2_valid;
            if (s2_valid) begin
                s3_pixel <= result_next;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output FIFO
    // ------------------------------------------------------------------
    logic [PIX_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;

    assign push      = s3_valid;
    assign out_valid = (fifo_count != '0);
    assign pop       = out_valid && out_ready;
    assign out_pixel = mem[rd_ptr];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= s3_pixel;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

endmodule
